// File: rtl/wishbone_pkg.sv
// wishbone_pkg: shared state encoding and constants for the Wishbone master bridge
package wishbone_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RELEASE = 2'd2} state_t;
  localparam int DEF_TIMEOUT = 255;
  localparam logic [63:0] WB_ERR_DATA = '1;
endpackage

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: saturating wait timer, expired on the edge that would complete TIMEOUT cycles
module wb_timeout_counter
  import wishbone_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] count;
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) count <= '0;
    else if (clr) count <= '0;
    else if (en && count != W'(TIMEOUT)) count <= count + W'(1);
  assign expired = count == W'(TIMEOUT - 1);
endmodule

// File: rtl/wishbone_master_bridge.sv
// wishbone_master_bridge: valid/ready request port to single Wishbone classic cycle with held-ack release and timeout
module wishbone_master_bridge
  import wishbone_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              we_o,
  output logic [DATA_W-1:0] data_o,
  output logic              cyc_o,
  output logic              stb_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic              ack_i
);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] data_d, rsp_data_d;
  logic we_d, cyc_d, rsp_valid_d, rsp_err_d, err_q, err_d, expired;
  assign req_ready_o = state_q == IDLE;
  assign stb_o = cyc_o;
  // timer restarts on every state change so BUS and RELEASE each get a full budget
  wb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr(state_q == IDLE || state_d != state_q),
    .en(state_q != IDLE),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_o;
    we_d = we_o;
    data_d = data_o;
    cyc_d = cyc_o;
    rsp_valid_d = 1'b0;
    rsp_data_d = rsp_data_o;
    rsp_err_d = rsp_err_o;
    err_d = err_q;
    case (state_q)
      IDLE: if (req_valid_i) begin
        state_d = BUS;
        addr_d = req_addr_i;
        we_d = req_we_i;
        data_d = req_data_i;
        cyc_d = 1'b1;
        err_d = 1'b0;
      end
      BUS: if (ack_i || expired) begin
        state_d = RELEASE;
        cyc_d = 1'b0;
        rsp_data_d = ack_i ? (we_o ? '0 : data_i) : WB_ERR_DATA[DATA_W-1:0];
        err_d = !ack_i;
      end
      RELEASE: if (!ack_i || expired) begin
        state_d = IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d = err_q | ack_i;
      end
      default: begin
        state_d = IDLE;
        addr_d = '0;
        we_d = 1'b0;
        data_d = '0;
        cyc_d = 1'b0;
        rsp_data_d = '0;
        rsp_err_d = 1'b0;
        err_d = 1'b0;
      end
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i)
    if (!rst_i) begin
      state_q <= IDLE;
      addr_o <= '0;
      we_o <= 1'b0;
      data_o <= '0;
      cyc_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_data_o <= '0;
      rsp_err_o <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_o <= addr_d;
      we_o <= we_d;
      data_o <= data_d;
      cyc_o <= cyc_d;
      rsp_valid_o <= rsp_valid_d;
      rsp_data_o <= rsp_data_d;
      rsp_err_o <= rsp_err_d;
      err_q <= err_d;
    end
endmodule
